// File: rtl/mc6847_pixel_pipeline.sv
// MC6847-style pixel data path: VRAM address, font lookup, dot select and colour map.
// Fixed 7-register pipeline with no stalls; control rides alongside the data.
module mc6847_pixel_pipeline #(
    parameter int VRAM_AW = 13,
    parameter int FONT_AW = 10
) (
    input  logic               pixel_clock,
    input  logic               reset,
    input  logic               blank,
    input  logic               show_border,
    input  logic [3:0]         subchar_pixel,
    input  logic [4:0]         subchar_line,
    input  logic [6:0]         char_column,
    input  logic [6:0]         char_line,
    input  logic [8:0]         graph_pixel,
    input  logic [9:0]         graph_line_2x,
    input  logic [9:0]         graph_line_3x,
    input  logic [1:0]         mode,
    input  logic               css,
    output logic [VRAM_AW-1:0] vram_addr,
    input  logic [7:0]         vram_data,
    output logic [FONT_AW-1:0] font_addr,
    input  logic [7:0]         font_data,
    output logic [3:0]         colour,
    output logic               blank_out
);

    localparam logic [1:0] MODE_TEXT = 2'd0;
    localparam logic [1:0] MODE_CG1  = 2'd1;

    localparam logic [3:0] C_GREEN    = 4'd0;
    localparam logic [3:0] C_BUFF     = 4'd4;
    localparam logic [3:0] C_ORANGE   = 4'd7;
    localparam logic [3:0] C_BLACK    = 4'd8;
    localparam logic [3:0] C_DKGREEN  = 4'd9;
    localparam logic [3:0] C_DKORANGE = 4'd10;

    typedef struct packed {
        logic [1:0] mode;
        logic       css;
        logic       blank;
        logic       border;
        logic [3:1] sub_px;
        logic [4:0] sub_ln;
        logic [3:1] gr_px;
    } ctrl_t;

    // Blank and border fill with 1 so a flushing pipeline shows black.
    localparam ctrl_t CTRL_RESET = '{mode: 2'd0, css: 1'b0, blank: 1'b1, border: 1'b1,
                                     sub_px: 3'd0, sub_ln: 5'd0, gr_px: 3'd0};

    ctrl_t              ctrl_d;
    ctrl_t              ctrl_q [1:6];
    logic [12:0]        addr_wide;
    logic [VRAM_AW-1:0] vram_addr_q, vram_addr_d;
    logic [7:0]         data3_q, data4_q, data5_q;
    logic [FONT_AW-1:0] font_addr_q, font_addr_d;
    logic               dot6_q, dot6_d;
    logic               sg6_q, sg6_d;
    logic [1:0]         pair6_q, pair6_d;
    logic [2:0]         sgcol6_q, sgcol6_d;
    logic [2:0]         cg_msb;
    logic [3:0]         colour_q, colour_d;
    logic               blank_out_q;

    logic unused_bits;
    assign unused_bits = ^{subchar_pixel[0], char_column[6:5], char_line[6:4],
                           graph_pixel[0], graph_line_2x[9], graph_line_2x[0],
                           graph_line_3x[9], graph_line_3x[2:0]};

    // R1: capture control and form the VRAM address for the current mode.
    always_comb begin
        ctrl_d = '{mode: mode, css: css, blank: blank, border: show_border,
                   sub_px: subchar_pixel[3:1], sub_ln: subchar_line,
                   gr_px: graph_pixel[3:1]};
        case (mode)
            MODE_TEXT: addr_wide = {4'd0, char_line[3:0], char_column[4:0]};
            MODE_CG1:  addr_wide = {2'd0, graph_line_3x[8:3], graph_pixel[8:4]};
            default:   addr_wide = {graph_line_2x[8:1], graph_pixel[8:4]};
        endcase
        vram_addr_d = VRAM_AW'(addr_wide);
    end

    // R4: only alphanumeric characters need a glyph row; otherwise the ROM address holds.
    always_comb begin
        font_addr_d = font_addr_q;
        if (ctrl_q[3].mode == MODE_TEXT && !data3_q[7]) begin
            font_addr_d = FONT_AW'({data3_q[5:0], ctrl_q[3].sub_ln[4:1]});
        end
    end

    // R6: pick the dot, quadrant or colour pair under the current pixel.
    always_comb begin
        dot6_d   = 1'b0;
        sg6_d    = 1'b0;
        pair6_d  = 2'd0;
        sgcol6_d = 3'd0;
        cg_msb   = 3'd7 - {ctrl_q[5].gr_px[3:2], 1'b0};
        case (ctrl_q[5].mode)
            MODE_TEXT: begin
                if (data5_q[7]) begin
                    sg6_d    = 1'b1;
                    sgcol6_d = data5_q[6:4];
                    dot6_d   = data5_q[{~(ctrl_q[5].sub_ln >= 5'd12), ~ctrl_q[5].sub_px[3]}];
                end else begin
                    dot6_d = font_data[3'd7 - ctrl_q[5].sub_px[3:1]] ^ data5_q[6];
                end
            end
            MODE_CG1: pair6_d = data5_q[cg_msb -: 2];
            default:  dot6_d  = data5_q[3'd7 - ctrl_q[5].gr_px[3:1]];
        endcase
    end

    // R7: colour mapping; blank beats border beats picture.
    always_comb begin
        colour_d = C_BLACK;
        if (ctrl_q[6].blank) begin
            colour_d = C_BLACK;
        end else if (ctrl_q[6].border) begin
            if (ctrl_q[6].mode == MODE_TEXT) colour_d = C_BLACK;
            else                             colour_d = ctrl_q[6].css ? C_BUFF : C_GREEN;
        end else begin
            case (ctrl_q[6].mode)
                MODE_TEXT: begin
                    if (sg6_q)       colour_d = dot6_q ? {1'b0, sgcol6_q} : C_BLACK;
                    else if (dot6_q) colour_d = ctrl_q[6].css ? C_ORANGE : C_GREEN;
                    else             colour_d = ctrl_q[6].css ? C_DKORANGE : C_DKGREEN;
                end
                MODE_CG1: colour_d = {1'b0, ctrl_q[6].css, pair6_q};
                default:  colour_d = dot6_q ? (ctrl_q[6].css ? C_BUFF : C_GREEN) : C_BLACK;
            endcase
        end
    end

    always_ff @(posedge pixel_clock or posedge reset) begin
        if (reset) begin
            for (int i = 1; i <= 6; i++) ctrl_q[i] <= CTRL_RESET;
            vram_addr_q <= '0;
            data3_q     <= 8'd0;
            data4_q     <= 8'd0;
            data5_q     <= 8'd0;
            font_addr_q <= '0;
            dot6_q      <= 1'b0;
            sg6_q       <= 1'b0;
            pair6_q     <= 2'd0;
            sgcol6_q    <= 3'd0;
            colour_q    <= C_BLACK;
            blank_out_q <= 1'b1;
        end else begin
            ctrl_q[1] <= ctrl_d;
            for (int i = 2; i <= 6; i++) ctrl_q[i] <= ctrl_q[i-1];
            vram_addr_q <= vram_addr_d;
            data3_q     <= vram_data;
            data4_q     <= data3_q;
            data5_q     <= data4_q;
            font_addr_q <= font_addr_d;
            dot6_q      <= dot6_d;
            sg6_q       <= sg6_d;
            pair6_q     <= pair6_d;
            sgcol6_q    <= sgcol6_d;
            colour_q    <= colour_d;
            blank_out_q <= ctrl_q[6].blank;
        end
    end

    assign vram_addr = vram_addr_q;
    assign font_addr = font_addr_q;
    assign colour    = colour_q;
    assign blank_out = blank_out_q;

endmodule

// File: tb/tb_mc6847_pixel_pipeline.sv
// Bench for mc6847_pixel_pipeline: memory models, a pixel-rule reference model,
// directed scenarios from the display rules and a randomized back-to-back sweep.
module tb_mc6847_pixel_pipeline;

    logic        clk = 1'b0;
    logic        rst;
    logic        blank, show_border, css;
    logic [3:0]  subchar_pixel;
    logic [4:0]  subchar_line;
    logic [6:0]  char_column, char_line;
    logic [8:0]  graph_pixel;
    logic [9:0]  graph_line_2x, graph_line_3x;
    logic [1:0]  mode;
    logic [12:0] vram_addr;
    logic [7:0]  vram_data;
    logic [9:0]  font_addr;
    logic [7:0]  font_data;
    logic [3:0]  colour;
    logic        blank_out;

    always #5 clk = ~clk;

    mc6847_pixel_pipeline #(.VRAM_AW(13), .FONT_AW(10)) dut (
        .pixel_clock(clk), .reset(rst), .blank(blank), .show_border(show_border),
        .subchar_pixel(subchar_pixel), .subchar_line(subchar_line),
        .char_column(char_column), .char_line(char_line),
        .graph_pixel(graph_pixel), .graph_line_2x(graph_line_2x),
        .graph_line_3x(graph_line_3x), .mode(mode), .css(css),
        .vram_addr(vram_addr), .vram_data(vram_data),
        .font_addr(font_addr), .font_data(font_data),
        .colour(colour), .blank_out(blank_out)
    );

    logic [7:0] vram [0:8191];
    logic [7:0] font [0:1023];

    always @(posedge clk) begin
        vram_data <= vram[vram_addr];
        font_data <= font[font_addr];
    end

    typedef struct packed {
        logic       blank;
        logic       border;
        logic [3:0] sp;
        logic [4:0] sl;
        logic [6:0] ccol;
        logic [6:0] cline;
        logic [8:0] gp;
        logic [9:0] gl2;
        logic [9:0] gl3;
        logic [1:0] mode;
        logic       css;
    } stim_t;

    int vectors, miscompares;

    logic [3:0]  q_col [$];
    logic        q_blk [$];
    logic [12:0] q_va  [$];
    logic [9:0]  q_fa  [$];
    bit          q_fchk [$];

    logic [3:0]  obs_col, exp_col;
    logic        obs_blk, exp_blk;
    logic [12:0] obs_va, exp_va;
    logic [9:0]  obs_fa, exp_fa;
    bit          exp_fchk;

    function automatic int ref_addr(stim_t s);
        case (s.mode)
            2'd0:    return int'(s.cline[3:0]) * 32 + int'(s.ccol[4:0]);
            2'd1:    return int'(s.gl3[8:3]) * 32 + int'(s.gp[8:4]);
            default: return int'(s.gl2[8:1]) * 32 + int'(s.gp[8:4]);
        endcase
    endfunction

    function automatic logic [3:0] ref_colour(stim_t s);
        logic [7:0] b, row;
        int q, p;
        logic dot;
        if (s.blank) return 4'd8;
        if (s.border) return (s.mode == 2'd0) ? 4'd8 : (s.css ? 4'd4 : 4'd0);
        b = vram[ref_addr(s)];
        case (s.mode)
            2'd0: begin
                if (b[7]) begin
                    q = (s.sl >= 5'd12 ? 0 : 2) + (s.sp >= 4'd8 ? 0 : 1);
                    return b[q] ? {1'b0, b[6:4]} : 4'd8;
                end
                row = font[int'(b[5:0]) * 16 + int'(s.sl) / 2];
                p   = int'(s.sp) / 2;
                dot = row[7 - p] ^ b[6];
                if (dot) return s.css ? 4'd7 : 4'd0;
                return s.css ? 4'd10 : 4'd9;
            end
            2'd1: begin
                p = int'(s.gp[3:2]);
                return 4'(((int'(b) >> (6 - 2 * p)) & 3) + (s.css ? 4 : 0));
            end
            default: begin
                p = int'(s.gp[3:1]);
                return b[7 - p] ? (s.css ? 4'd4 : 4'd0) : 4'd8;
            end
        endcase
    endfunction

    function automatic stim_t rand_stim();
        stim_t s;
        s.blank  = ($urandom_range(7) == 0);
        s.border = ($urandom_range(7) == 0);
        s.sp     = 4'($urandom);
        s.sl     = 5'($urandom_range(23));
        s.ccol   = 7'($urandom_range(31));
        s.cline  = 7'($urandom_range(15));
        s.gp     = 9'($urandom);
        s.gl2    = 10'($urandom);
        s.gl3    = 10'($urandom);
        s.mode   = 2'($urandom);
        s.css    = 1'($urandom);
        return s;
    endfunction

    task automatic apply(input stim_t s);
        blank = s.blank; show_border = s.border; subchar_pixel = s.sp;
        subchar_line = s.sl; char_column = s.ccol; char_line = s.cline;
        graph_pixel = s.gp; graph_line_2x = s.gl2; graph_line_3x = s.gl3;
        mode = s.mode; css = s.css;
    endtask

    task automatic reset_queues();
        q_col.delete(); q_blk.delete(); q_va.delete(); q_fa.delete(); q_fchk.delete();
        repeat (7) begin q_col.push_back(4'd8); q_blk.push_back(1'b1); end
        q_va.push_back(13'd0);
        repeat (4) begin q_fa.push_back(10'd0); q_fchk.push_back(1'b1); end
    endtask

    // One pixel: sample outputs, pop what they should be, drive the next pixel, predict it.
    task automatic tick(input stim_t s, input bit release_rst);
        logic [7:0] b;
        int a;
        @(negedge clk);
        if (release_rst) begin
            rst = 1'b0;
            reset_queues();
        end
        obs_col = colour; obs_blk = blank_out; obs_va = vram_addr; obs_fa = font_addr;
        exp_col = q_col.pop_front(); exp_blk = q_blk.pop_front();
        exp_va = q_va.pop_front(); exp_fa = q_fa.pop_front(); exp_fchk = q_fchk.pop_front();
        apply(s);
        a = ref_addr(s);
        b = vram[a];
        q_col.push_back(ref_colour(s));
        q_blk.push_back(s.blank);
        q_va.push_back(13'(a));
        if (s.mode == 2'd0 && !b[7]) begin
            q_fa.push_back(10'(int'(b[5:0]) * 16 + int'(s.sl) / 2));
            q_fchk.push_back(1'b1);
        end else begin
            q_fa.push_back(10'd0);
            q_fchk.push_back(1'b0);
        end
    endtask

    task automatic test_reset();
        stim_t s;
        s = '0; s.blank = 1'b1;
        rst = 1'b1;
        apply(s);
        repeat (3) @(negedge clk);
        vectors += 4;
        if (colour !== 4'd8) begin miscompares++; $display("FAIL reset_colour: got %0d want 8", colour); end
        if (blank_out !== 1'b1) begin miscompares++; $display("FAIL reset_blank_out: got %0b want 1", blank_out); end
        if (vram_addr !== 13'd0) begin miscompares++; $display("FAIL reset_vram_addr: got %h want 0", vram_addr); end
        if (font_addr !== 10'd0) begin miscompares++; $display("FAIL reset_font_addr: got %h want 0", font_addr); end
        s = '0; s.mode = 2'd1; s.css = 1'b1; s.gl3 = 10'd88; s.gp = 9'd50;
        for (int k = 0; k < 9; k++) begin
            tick(s, k == 0);
            vectors += 2;
            if (k < 7) begin
                if (obs_col !== 4'd8) begin miscompares++; $display("FAIL release_colour k=%0d: got %0d want 8", k, obs_col); end
                if (obs_blk !== 1'b1) begin miscompares++; $display("FAIL release_blank k=%0d: got %0b want 1", k, obs_blk); end
            end else begin
                if (obs_col !== exp_col) begin miscompares++; $display("FAIL release_first_pixel k=%0d: got %0d want %0d", k, obs_col, exp_col); end
                if (obs_blk !== 1'b0) begin miscompares++; $display("FAIL release_first_blank k=%0d: got %0b want 0", k, obs_blk); end
            end
        end
    endtask

    task automatic test_text(input logic [6:0] col, input logic inv);
        stim_t s;
        logic [3:0] want;
        bit edge_dot;
        s = '0; s.cline = 7'd2; s.ccol = col;
        for (int j = 0; j < 23; j++) begin
            s.sp = (j < 16) ? 4'(j) : 4'd15;
            s.sl = 5'(j % 2);
            tick(s, 1'b0);
            if (j >= 1 && j <= 16) begin
                vectors++;
                if (obs_va !== (13'h040 | 13'(col))) begin miscompares++; $display("FAIL text_vram_addr j=%0d: got %h want %h", j, obs_va, 13'h040 | 13'(col)); end
            end
            if (j >= 4 && j <= 19) begin
                vectors++;
                if (obs_fa !== 10'h010) begin miscompares++; $display("FAIL text_font_addr j=%0d: got %h want 010", j, obs_fa); end
            end
            if (j >= 7) begin
                edge_dot = ((j - 7) / 2 == 0) || ((j - 7) / 2 == 7);
                want = (edge_dot ^ inv) ? 4'd0 : 4'd9;
                vectors++;
                if (obs_col !== want) begin miscompares++; $display("FAIL text_dot inv=%0b px=%0d: got %0d want %0d", inv, j - 7, obs_col, want); end
            end
        end
    endtask

    task automatic test_sg4();
        stim_t s;
        int sp_t [4] = '{0, 8, 0, 8};
        int sl_t [4] = '{0, 0, 12, 12};
        int want [4] = '{2, 8, 8, 2};
        int q;
        s = '0; s.ccol = 7'd5; s.cline = 7'd1;
        for (int j = 0; j < 11; j++) begin
            q = (j < 4) ? j : 3;
            s.sp = 4'(sp_t[q]); s.sl = 5'(sl_t[q]);
            tick(s, 1'b0);
            if (j >= 7) begin
                vectors++;
                if (obs_col !== 4'(want[j - 7])) begin miscompares++; $display("FAIL sg4_quadrant %0d: got %0d want %0d", j - 7, obs_col, want[j - 7]); end
            end
        end
    endtask

    task automatic test_cg1();
        stim_t s;
        s = '0; s.mode = 2'd1; s.css = 1'b1; s.gl3 = 10'd40;
        for (int j = 0; j < 23; j++) begin
            s.gp = 9'h020 + 9'((j < 16) ? j : 15);
            tick(s, 1'b0);
            if (j >= 1 && j <= 16) begin
                vectors++;
                if (obs_va !== 13'h0A2) begin miscompares++; $display("FAIL cg1_vram_addr j=%0d: got %h want 0a2", j, obs_va); end
            end
            if (j >= 7) begin
                vectors++;
                if (obs_col !== 4'(4 + (j - 7) / 4)) begin miscompares++; $display("FAIL cg1_pixel %0d: got %0d want %0d", j - 7, obs_col, 4 + (j - 7) / 4); end
            end
        end
    endtask

    task automatic test_rg6_border_blank();
        stim_t s;
        s = '0; s.mode = 2'd2; s.css = 1'b1; s.border = 1'b1;
        for (int j = 0; j < 9; j++) begin
            s.blank = (j >= 1);
            tick(s, 1'b0);
            if (j == 7) begin
                vectors += 2;
                if (obs_col !== 4'd4) begin miscompares++; $display("FAIL rg6_border: got %0d want 4", obs_col); end
                if (obs_blk !== 1'b0) begin miscompares++; $display("FAIL rg6_border_blank_out: got %0b want 0", obs_blk); end
            end
            if (j == 8) begin
                vectors += 2;
                if (obs_col !== 4'd8) begin miscompares++; $display("FAIL rg6_blank: got %0d want 8", obs_col); end
                if (obs_blk !== 1'b1) begin miscompares++; $display("FAIL rg6_blank_out: got %0b want 1", obs_blk); end
            end
        end
    endtask

    task automatic test_random(input int n, input bit first_release);
        for (int k = 0; k < n; k++) begin
            tick(rand_stim(), first_release && k == 0);
            vectors += 3;
            if (obs_col !== exp_col) begin miscompares++; $display("FAIL random_colour k=%0d: got %0d want %0d", k, obs_col, exp_col); end
            if (obs_blk !== exp_blk) begin miscompares++; $display("FAIL random_blank_out k=%0d: got %0b want %0b", k, obs_blk, exp_blk); end
            if (obs_va !== exp_va) begin miscompares++; $display("FAIL random_vram_addr k=%0d: got %h want %h", k, obs_va, exp_va); end
            if (exp_fchk) begin
                vectors++;
                if (obs_fa !== exp_fa) begin miscompares++; $display("FAIL random_font_addr k=%0d: got %h want %h", k, obs_fa, exp_fa); end
            end
        end
    endtask

    task automatic test_reset_midline();
        test_random(60, 1'b0);
        #2 rst = 1'b1;
        #1;
        vectors += 4;
        if (colour !== 4'd8) begin miscompares++; $display("FAIL midline_reset_colour: got %0d want 8", colour); end
        if (blank_out !== 1'b1) begin miscompares++; $display("FAIL midline_reset_blank_out: got %0b want 1", blank_out); end
        if (vram_addr !== 13'd0) begin miscompares++; $display("FAIL midline_reset_vram_addr: got %h want 0", vram_addr); end
        if (font_addr !== 10'd0) begin miscompares++; $display("FAIL midline_reset_font_addr: got %h want 0", font_addr); end
        repeat (2) @(negedge clk);
        test_random(300, 1'b1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        vectors = 0;
        miscompares = 0;
        for (int i = 0; i < 8192; i++) vram[i] = 8'($urandom);
        for (int i = 0; i < 1024; i++) font[i] = 8'($urandom);
        vram[0]      = 8'h00;
        vram[13'h043] = 8'h01;
        vram[13'h044] = 8'h41;
        vram[13'h025] = 8'hA9;
        vram[13'h0A2] = 8'h1B;
        font[10'h010] = 8'h81;
        test_reset();
        test_text(7'd3, 1'b0);
        test_text(7'd4, 1'b1);
        test_sg4();
        test_cg1();
        test_rg6_border_blank();
        test_random(3000, 1'b0);
        test_reset_midline();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
